// File: rtl/capture_sequencer_if.sv
// rtl/capture_sequencer_if.sv - upstream 16-bit word valid/ready handshake
interface capture_sequencer_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - buffers upstream words and presents each as a two-cycle load pair
// Optional CAPTURE_CHECKSUM_EN adds a running 16-bit sum of popped words.
module capture_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] start_base,
    input  logic [15:0] word_count,
    capture_sequencer_if.slave up,
    output logic        load,
    output logic [15:0] captured_data,
    output logic [15:0] ramBase,
    output logic        busy,
    output logic        done
`ifdef CAPTURE_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EMIT_HI = 3'd2,
        EMIT_LO = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t      state_q, state_d;

    logic [15:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q;
    logic [15:0] captured_q;
    logic [15:0] ram_base_q;
    logic [15:0] remaining_q;

    logic fifo_empty, fifo_full;
    logic push, pop, flush, start_acc, last_word;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    assign last_word  = (remaining_q == 16'd1);
    assign push       = up.in_valid && up.in_ready;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (word_count == 16'd0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (!fifo_empty) begin
                    state_d = EMIT_HI;
                end
            end
            EMIT_HI: state_d = EMIT_LO;
            EMIT_LO: begin
                if (last_word) begin
                    state_d = FINISH;
                end else if (!fifo_empty) begin
                    state_d = EMIT_HI;
                end else begin
                    state_d = FETCH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load        = (state_q == EMIT_HI) || (state_q == EMIT_LO);
        busy        = (state_q == FETCH) || load;
        done        = (state_q == FINISH);
        up.in_ready = busy && !fifo_full;
        start_acc   = (state_q == IDLE) && start;
        flush       = (state_q == FINISH);
        // EMIT_LO pops ahead so the next pair follows without a gap
        pop         = !fifo_empty &&
                      ((state_q == FETCH) || ((state_q == EMIT_LO) && !last_word));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up.in_data;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            captured_q  <= '0;
            ram_base_q  <= '0;
            remaining_q <= '0;
        end else begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
            end
            if (pop) begin
                captured_q <= mem_q[rd_ptr_q];
            end
            if (start_acc) begin
                ram_base_q  <= start_base;
                remaining_q <= word_count;
            end else if (state_q == EMIT_LO) begin
                ram_base_q  <= ram_base_q + 16'd2;
                remaining_q <= remaining_q - 16'd1;
            end
        end
    end

    assign captured_data = captured_q;
    assign ramBase       = ram_base_q;

`ifdef CAPTURE_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            checksum_q <= '0;
        end else if (start_acc) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q + mem_q[rd_ptr_q];
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
